// File: rtl/sprite_plotter.sv
// Rasterises one 4x4 sprite per accepted request into per-pixel VGA writes, then pulses done.
// Latency: pixel 0 appears in the cycle right after the accept edge; 16 pixel slots, then 1 done cycle (18 cycles accept-to-accept).
// Backpressure: req_ready is high only in IDLE; a held request waits there and is taken on the first IDLE edge.
module sprite_plotter #(
    parameter int         X_MAX        = 159,
    parameter int         Y_MAX        = 119,
    parameter logic [2:0] ERASE_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_x,
    input  logic [6:0] req_y,
    input  logic [2:0] req_colour,
    input  logic [1:0] req_shape,
    input  logic       req_erase,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       done
);

    localparam logic [8:0] X_LIM = 9'(X_MAX);
    localparam logic [7:0] Y_LIM = 8'(Y_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;

    // Request fields captured at the accept edge; later input changes are ignored.
    logic [7:0] x0;
    logic [6:0] y0;
    logic [2:0] col0;
    logic [1:0] shape0;
    logic       erase0;

    logic       accept;
    logic       last_slot;

    // Source of the next pixel to present: live request on accept, latched fields while drawing.
    logic [7:0] src_x;
    logic [6:0] src_y;
    logic [2:0] src_col;
    logic [1:0] src_shape;
    logic       src_erase;
    logic [3:0] src_k;
    logic [1:0] src_r;
    logic [1:0] src_c;
    logic [1:0] col_idx;
    logic [3:0] mask_bits;
    logic [8:0] px;
    logic [7:0] py;
    logic       pix_plot;
    logic [2:0] pix_colour;

    // Row masks; bit 3 is the leftmost column.
    function automatic logic [3:0] mask_row(input logic [1:0] shape, input logic [1:0] r);
        logic [3:0] m;
        m = 4'h0;
        case (shape)
            2'd0: m = 4'hF;
            2'd1: case (r)
                      2'd0:    m = 4'h6;
                      2'd1:    m = 4'h6;
                      2'd2:    m = 4'hF;
                      default: m = 4'h9;
                  endcase
            2'd2: case (r)
                      2'd0:    m = 4'h6;
                      2'd1:    m = 4'hF;
                      2'd2:    m = 4'h9;
                      default: m = 4'h6;
                  endcase
            default: m = (r == 2'd3) ? 4'h0 : 4'h4;
        endcase
        return m;
    endfunction

    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign last_slot = (cnt == 4'd15);

    // Select the pixel source and evaluate mask, clipping and colour for it.
    always_comb begin
        src_x     = x0;
        src_y     = y0;
        src_col   = col0;
        src_shape = shape0;
        src_erase = erase0;
        src_k     = cnt + 4'd1;
        if (state == IDLE) begin
            src_x     = req_x;
            src_y     = req_y;
            src_col   = req_colour;
            src_shape = req_shape;
            src_erase = req_erase;
            src_k     = 4'd0;
        end
        src_r      = src_k[3:2];
        src_c      = src_k[1:0];
        col_idx    = 2'd3 - src_c;
        mask_bits  = mask_row(src_shape, src_r);
        // Widened sums so a sprite near the right/bottom edge clips instead of wrapping.
        px         = {1'b0, src_x} + {7'b0, src_c};
        py         = {1'b0, src_y} + {6'b0, src_r};
        pix_plot   = (src_erase || mask_bits[col_idx]) && (px <= X_LIM) && (py <= Y_LIM);
        pix_colour = src_erase ? ERASE_COLOUR : src_col;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = DRAW;
            DRAW:    if (last_slot) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Slot counter, request capture and registered pixel outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= 4'd0;
            x0         <= 8'd0;
            y0         <= 7'd0;
            col0       <= 3'd0;
            shape0     <= 2'd0;
            erase0     <= 1'b0;
            vga_x      <= 8'd0;
            vga_y      <= 7'd0;
            vga_colour <= 3'd0;
            vga_plot   <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done     <= 1'b0;
                    vga_plot <= 1'b0;
                    if (accept) begin
                        x0         <= req_x;
                        y0         <= req_y;
                        col0       <= req_colour;
                        shape0     <= req_shape;
                        erase0     <= req_erase;
                        cnt        <= 4'd0;
                        vga_x      <= px[7:0];
                        vga_y      <= py[6:0];
                        vga_colour <= pix_colour;
                        vga_plot   <= pix_plot;
                    end
                end
                DRAW: begin
                    if (last_slot) begin
                        vga_plot <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        cnt        <= cnt + 4'd1;
                        vga_x      <= px[7:0];
                        vga_y      <= py[6:0];
                        vga_colour <= pix_colour;
                        vga_plot   <= pix_plot;
                    end
                end
                default: begin
                    done     <= 1'b0;
                    vga_plot <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_plotter.sv
// Directed bench for sprite_plotter: reset state, each shape, erase, clipping, back-to-back and mid-draw reset.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
// Expected plot patterns are hand-derived 16-bit slot vectors (bit k = slot k).
module tb_sprite_plotter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_x;
    logic [6:0] req_y;
    logic [2:0] req_colour;
    logic [1:0] req_shape;
    logic       req_erase;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       done;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int acc_cyc;
    int first_acc;

    always #5 clk = ~clk;

    // Free-running cycle counter used to time accepts.
    always @(posedge clk) cyc <= cyc + 1;

    sprite_plotter dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_colour (req_colour),
        .req_shape  (req_shape),
        .req_erase  (req_erase),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .done       (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present a request at a falling edge and let the next rising edge accept it.
    task automatic send(input int x, input int y, input int col, input int shape,
                        input int erase, input bit hold);
        @(negedge clk);
        req_x      = 8'(x);
        req_y      = 7'(y);
        req_colour = 3'(col);
        req_shape  = 2'(shape);
        req_erase  = 1'(erase);
        req_valid  = 1'b1;
        chk("ready_before_accept", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (!hold) req_valid = 1'b0;
    endtask

    // Check 16 pixel slots, the done cycle and the return of ready.
    task automatic draw_check(input int x0, input int y0, input int col, input logic [15:0] pv,
                              input int chg_slot, input int newx);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk($sformatf("plot_k%0d", k), 32'(vga_plot), 32'(pv[k]));
            chk($sformatf("x_k%0d", k), 32'(vga_x), 32'((x0 + (k % 4)) & 255));
            chk($sformatf("y_k%0d", k), 32'(vga_y), 32'((y0 + (k / 4)) & 127));
            chk($sformatf("colour_k%0d", k), 32'(vga_colour), 32'(col));
            chk($sformatf("done_low_k%0d", k), 32'(done), 32'd0);
            if (k == chg_slot) req_x = 8'(newx);
        end
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd1);
        chk("plot_low_in_done", 32'(vga_plot), 32'd0);
        chk("ready_low_in_done", 32'(req_ready), 32'd0);
        chk("x_hold_in_done", 32'(vga_x), 32'((x0 + 3) & 255));
        chk("y_hold_in_done", 32'(vga_y), 32'((y0 + 3) & 127));
        @(negedge clk);
        chk("done_cleared", 32'(done), 32'd0);
        chk("ready_returns", 32'(req_ready), 32'd1);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_x      = 8'd0;
        req_y      = 7'd0;
        req_colour = 3'd0;
        req_shape  = 2'd0;
        req_erase  = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_plot", 32'(vga_plot), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_x", 32'(vga_x), 32'd0);
        chk("rst_y", 32'(vga_y), 32'd0);
        chk("rst_colour", 32'(vga_colour), 32'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", 32'(req_ready), 32'd1);

        // Box at (10,20), colour 100: all 16 slots plot.
        send(10, 20, 3'b100, 0, 0, 1'b0);
        draw_check(10, 20, 3'b100, 16'hFFFF, -1, 0);

        // Ship at (0,0), colour 010: slots 1,2,5,6,8..11,12,15.
        send(0, 0, 3'b010, 1, 0, 1'b0);
        draw_check(0, 0, 3'b010, 16'h9F66, -1, 0);

        // Alien at (40,40) erased: mask ignored, colour forced to 000.
        send(40, 40, 3'b111, 2, 1, 1'b0);
        draw_check(40, 40, 3'b000, 16'hFFFF, -1, 0);

        // Bullet at (5,5): column 1 of rows 0..2.
        send(5, 5, 3'b011, 3, 0, 1'b0);
        draw_check(5, 5, 3'b011, 16'h0222, -1, 0);

        // Box at (158,118): only slots 0,1,4,5 survive clipping, timing unchanged.
        send(158, 118, 3'b001, 0, 0, 1'b0);
        first_acc = acc_cyc;
        draw_check(158, 118, 3'b001, 16'h0033, -1, 0);
        send(1, 1, 3'b110, 0, 0, 1'b0);
        chk("clip_accept_spacing", 32'(acc_cyc - first_acc), 32'd19);
        draw_check(1, 1, 3'b110, 16'hFFFF, -1, 0);

        // Back-to-back with valid held; req_x changes mid-draw.
        send(50, 10, 3'b101, 0, 0, 1'b1);
        first_acc = acc_cyc;
        draw_check(50, 10, 3'b101, 16'hFFFF, 5, 99);
        @(posedge clk);
        #1;
        chk("b2b_accept_spacing", 32'(cyc - first_acc), 32'd18);
        req_valid = 1'b0;
        draw_check(99, 10, 3'b101, 16'hFFFF, -1, 0);

        // Reset while slot 7 is on the outputs.
        send(30, 30, 3'b101, 0, 0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("pre_rst_plot_k%0d", k), 32'(vga_plot), 32'd1);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_plot", 32'(vga_plot), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_x", 32'(vga_x), 32'd0);
        reset = 1'b0;
        #1;
        chk("ready_first_cycle_after_rst", 32'(req_ready), 32'd1);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst_no_done_%0d", k), 32'(done), 32'd0);
            chk($sformatf("post_rst_no_plot_%0d", k), 32'(vga_plot), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sprite_plotter.md
Name: sprite_plotter

Overview:
- Responder end of the object-draw request interface. The frame sequencer and object mux issue one request per object: position, colour, shape and erase flag.
- The block accepts the request with a valid/ready handshake. It rasterises a 4x4 sprite into per-pixel writes for the VGA adapter (x, y, colour, plot), then pulses done so the sequencer can advance to the next object.

Parameters:
- X_MAX, 159, largest legal screen x; pixels with x > X_MAX are suppressed.
- Y_MAX, 119, largest legal screen y; pixels with y > Y_MAX are suppressed.
- ERASE_COLOUR, 3'b000, colour written when erase=1.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_x  in  8  sprite top-left x.
- req_y  in  7  sprite top-left y.
- req_colour  in  3  draw colour.
- req_shape  in  2  0=box, 1=ship, 2=alien, 3=bullet.
- req_erase  in  1  1 = clear the full 4x4 footprint.
- vga_x  out  8  pixel x.
- vga_y  out  7  pixel y.
- vga_colour  out  3  pixel colour.
- vga_plot  out  1  write-enable for the current pixel.
- done  out  1  one-cycle pulse after the last pixel of a sprite.

Behaviour:
- States: IDLE, DRAW, DONE. Reset forces IDLE, cnt=0, and all outputs 0.
- req_ready = (state==IDLE) && !reset. It is combinational, so it is 0 during reset.
- IDLE:
  - On a clock edge with req_valid && req_ready, latch x, y, colour, shape and erase; cnt<=0; go to DRAW.
  - Inputs are ignored at all other times, and changes after acceptance have no effect.
- DRAW:
  - One pixel per cycle, k=cnt in 0..15, raster order: r=k[3:2], c=k[1:0].
  - px = x0+c, computed 9 bits wide. py = y0+r, computed 8 bits wide.
  - Outputs are registered. Pixel k is visible on vga_* during the (k+1)-th cycle after the accept edge.
  - vga_x=px[7:0], vga_y=py[6:0].
  - vga_plot = mask(shape,r,c) && px<=X_MAX && py<=Y_MAX. When erase=1 the mask is treated as all ones.
  - vga_colour = erase ? ERASE_COLOUR : colour.
  - Every one of the 16 slots takes exactly one cycle, even when vga_plot=0, so timing is fixed.
  - After k=15, go to DONE.
- DONE: done=1 and vga_plot=0 for exactly one cycle, then IDLE.
- Accept-to-next-accept minimum is 18 cycles.
- Outside DRAW, vga_plot=0. vga_x, vga_y and vga_colour hold their last values.
- Mask rows, r=0..3, bit3 = column 0 (leftmost):
  - box: F,F,F,F
  - ship: 6,6,F,9
  - alien: 6,F,9,6
  - bullet: 4,4,4,0
- Clipping: no wrap-around. x0=158 plots only columns 0–1. y0=118 plots only rows 0–1. Suppressed slots still consume cycles.
- Reset mid-DRAW or in DONE:
  - The next state is IDLE. vga_plot and done are 0 on the edge following reset assertion, and no further pixels are emitted.
  - req_ready rises in the first cycle with reset low.
- A request held valid during DRAW or DONE is not accepted until IDLE. It is accepted on the first IDLE edge.

Test Plan:
- Box at (10,20), colour 3'b100: 16 consecutive plot cycles; first pixel (10,20), last pixel (13,23); done pulses on cycle 17; ready returns on cycle 18.
- Ship at (0,0), colour 3'b010: plot high only for slots k=1,2,5,6,8..11,12,15; colour 010 on every plotted pixel.
- Alien at (40,40) with erase=1: all 16 slots plot colour 000, mask ignored.
- Box at (158,118): only pixels (158,118), (159,118), (158,119), (159,119) plot; total 18 cycles between accepts unchanged.
- Back-to-back requests with req_valid held high: second accept occurs exactly 18 cycles after the first; req_x changed mid-DRAW does not alter the current sprite.
- Reset asserted at slot k=7: on the following edge vga_plot=0 and done=0; no done pulse follows; req_ready=1 the first cycle reset is low.
